// File: rtl/age_order_tracker.sv
// age_order_tracker
//   Allocation side and age bookkeeping for an NENT-entry out-of-order
//   buffer. Free slots are handed out lowest-index first. Each new entry
//   is recorded as younger than every entry that is still live. Every
//   cycle the oldest entry that is both valid and ready is offered to the
//   issue stage. That entry is freed when the offer is acknowledged.
//
// Ports
//   clk, rst     clock and synchronous active-high reset
//   flush        drop every entry at the next edge; wins over alloc/issue
//   alloc_req    dispatch wants one entry this cycle
//   alloc_gnt    request accepted; the entry is taken at this edge
//   alloc_idx    index of the lowest free slot (0 when full)
//   alloc_oh     one-hot form of alloc_idx (zero when full)
//   rdy          per-entry ready; only meaningful for valid entries
//   iss_vld      some valid entry is ready
//   iss_oh       one-hot oldest valid and ready entry
//   iss_idx      binary form of iss_oh
//   iss_ack      issue stage takes the pick at this edge
//   valid        registered entry-valid vector
//   count        registered number of valid entries
//   full, empty  count == NENT, count == 0
module age_order_tracker #(
    parameter int NENT = 8,
    parameter int IDXW = $clog2(NENT),
    parameter int CNTW = $clog2(NENT + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alloc_req,
    output logic            alloc_gnt,
    output logic [IDXW-1:0] alloc_idx,
    output logic [NENT-1:0] alloc_oh,
    input  logic [NENT-1:0] rdy,
    output logic            iss_vld,
    output logic [NENT-1:0] iss_oh,
    output logic [IDXW-1:0] iss_idx,
    input  logic            iss_ack,
    output logic [NENT-1:0] valid,
    output logic [CNTW-1:0] count,
    output logic            full,
    output logic            empty
);

    // age_reg[i][j] = 1 means entry i is older than entry j.
    logic [NENT-1:0][NENT-1:0] age_reg;
    logic [NENT-1:0][NENT-1:0] age_next;
    logic [NENT-1:0]           valid_reg;
    logic [NENT-1:0]           valid_kept;
    logic [NENT-1:0]           valid_next;
    logic [CNTW-1:0]           count_reg;
    logic [CNTW-1:0]           count_next;

    logic [NENT-1:0]           vr;
    logic [NENT-1:0]           pick_oh;
    logic [NENT-1:0]           free_oh;
    logic [IDXW-1:0]           free_idx;
    logic                      free_found;
    logic                      iss_fire;

    assign valid = valid_reg;
    assign count = count_reg;
    assign full  = (count_reg == CNTW'(NENT));
    assign empty = (count_reg == '0);

    // Lowest-numbered free slot. The search runs from the top down so
    // that the lowest free index is the last one written.
    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = NENT - 1; i >= 0; i--) begin
            if (!valid_reg[i]) begin
                free_idx   = IDXW'(i);
                free_found = 1'b1;
            end
        end
    end

    assign free_oh   = free_found ? ({{(NENT-1){1'b0}}, 1'b1} << free_idx) : '0;
    assign alloc_idx = free_idx;
    assign alloc_oh  = free_oh;
    assign alloc_gnt = alloc_req & ~full & ~rst & ~flush;

    // Oldest-ready pick. An entry wins when no other valid and ready
    // entry is older than it, that is, when its column holds no ready bit.
    assign vr = valid_reg & rdy;

    generate
        for (genvar gi = 0; gi < NENT; gi++) begin : g_entry
            logic [NENT-1:0] col;    // col[j] = age_reg[j][gi]
            logic [NENT-1:0] row_kept;

            for (genvar gj = 0; gj < NENT; gj++) begin : g_col
                assign col[gj] = age_reg[gj][gi];
            end

            assign pick_oh[gi] = vr[gi] & ~|(vr & col);

            // Issue clears the row and the column of the departing entry.
            assign row_kept = !iss_fire   ? age_reg[gi] :
                              iss_oh[gi]  ? '0 :
                                            (age_reg[gi] & ~iss_oh);

            // Allocation clears the row of the new entry. It then marks
            // every entry that survives this edge as older than the new one.
            assign age_next[gi] = !alloc_gnt  ? row_kept :
                                  free_oh[gi] ? '0 :
                                                ((row_kept & ~free_oh) |
                                                 (valid_kept[gi] ? free_oh : '0));

            always_ff @(posedge clk) begin
                if (!rst) begin
                    assert ((age_reg[gi] & col) == '0)
                        else $error("age matrix not antisymmetric at entry %0d", gi);
                end
            end
        end
    endgenerate

    assign iss_oh   = rst ? '0 : pick_oh;
    assign iss_vld  = |iss_oh;
    assign iss_fire = iss_vld & iss_ack & ~flush;

    always_comb begin
        iss_idx = '0;
        for (int i = 0; i < NENT; i++) begin
            if (iss_oh[i]) begin
                iss_idx = iss_idx | IDXW'(i);
            end
        end
    end

    // The slot freed by issue at this edge is not handed out again until
    // the next cycle, because free_oh is derived from the pre-edge valid_reg.
    assign valid_kept = valid_reg & ~(iss_fire ? iss_oh : '0);
    assign valid_next = valid_kept | (alloc_gnt ? free_oh : '0);
    assign count_next = count_reg + CNTW'(alloc_gnt) - CNTW'(iss_fire);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_reg <= '0;
            age_reg   <= '0;
            count_reg <= '0;
        end else begin
            valid_reg <= valid_next;
            age_reg   <= age_next;
            count_reg <= count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(iss_oh))
                else $error("iss_oh has more than one bit set");
            assert ($countones(valid_reg) == int'(count_reg))
                else $error("count disagrees with valid vector");
        end
    end

endmodule

// File: doc/age_order_tracker.md
Name: age_order_tracker

Overview:
Sequential age-matrix tracker for an NENT-entry out-of-order buffer; it is the writer/allocation side that feeds the age comparison.
- Allocates free slots in arrival order and records relative age in an NENT x NENT matrix.
- Each cycle it selects the oldest valid entry whose ready bit is set, and frees that entry when issue is handshaked.
- It sits between the dispatch stage, which allocates, and the issue stage, which consumes the oldest-ready pick.

Parameters:
NENT, 8, number of tracked entries (>=2)
IDXW, CLOG2(NENT), width of binary entry index
CNTW, CLOG2(NENT+1), width of the occupancy count

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
flush  in  1  invalidate all entries next edge; priority over alloc and issue
alloc_req  in  1  request one new entry this cycle
alloc_gnt  out  1  alloc_req & ~full & ~rst & ~flush; entry taken at this edge
alloc_idx  out  IDXW  binary index of lowest-numbered free entry (0 when full)
alloc_oh  out  NENT  one-hot form of alloc_idx (all-zero when full)
rdy  in  NENT  per-entry ready; ignored for invalid entries
iss_vld  out  1  some entry is valid & ready
iss_oh  out  NENT  one-hot oldest valid & ready entry (all-zero if none)
iss_idx  out  IDXW  binary encode of iss_oh (0 if none)
iss_ack  in  1  consumer accepts pick; entry freed at edge when iss_vld & iss_ack
valid  out  NENT  registered entry-valid vector
count  out  CNTW  registered number of valid entries
full  out  1  count == NENT
empty  out  1  count == 0

Behaviour:
- State: valid[NENT], age[i][j] (1 = entry i older than j), count; all registered. The diagonal is never set.
- Reset (rst=1 at edge): valid=0, age=0, count=0.
  - While rst is high: alloc_gnt=0, iss_vld=0, iss_oh=0.
  - After reset: empty=1, full=0, alloc_idx=0, alloc_oh=1.
- Allocation (alloc_gnt=1, index k = lowest i with valid[i]=0):
  - Next cycle valid[k]=1.
  - Row k is cleared.
  - Column k is set: age[i][k]=valid[i] for all i != k, using current valid after the same-edge issue removal is applied.
  - The new entry is therefore younger than every surviving entry.
- Pick (combinational from registered state):
  - vr = valid & rdy.
  - iss_oh[i] = vr[i] & ~|(for j: vr[j] & age[j][i]).
  - Exactly one bit is set when vr != 0. Zero-latency from rdy.
- Issue (iss_vld & iss_ack at edge, entry m):
  - Next cycle valid[m]=0.
  - Row m and column m are cleared.
  - iss_ack without iss_vld has no effect.
- Allocation in the same cycle as issue:
  - Both occur and count is unchanged.
  - The freed slot is not reusable in that cycle, because alloc_idx is based on pre-edge valid.
  - The newly allocated entry is not eligible for issue until the following cycle.
- count next = count + alloc_gnt - (iss_vld & iss_ack); it never wraps.
- full: alloc_req is ignored (alloc_gnt=0); issue still proceeds.
- empty: iss_vld=0 regardless of rdy.
- flush at edge: valid=0, age=0, count=0. Concurrent alloc_gnt is forced 0 and the issue ack is dropped.
- Reset mid-operation: state is cleared on the next edge; no partial updates.
- Assertions:
  - iss_oh is onehot0.
  - age[i][j] & age[j][i] is never true.
  - count == popcount(valid).

Test Plan:
1. NENT=4; reset, then alloc_req on 4 consecutive cycles -> alloc_idx 0,1,2,3, count 1..4, full=1 after the 4th; a 5th alloc_req gives alloc_gnt=0.
2. Fill 0..3 in order; rdy=4'b1010 -> iss_oh=4'b0010, iss_idx=1. Ack -> valid=4'b1101; next pick iss_oh=4'b1000.
3. Fill order 0,1,2; issue 0; alloc gets 0 (now youngest); rdy=4'b0101 -> iss_oh=4'b0100 (entry 2 older than re-allocated 0).
4. Full (count=4): alloc_req + iss_ack on entry 2 in the same cycle -> alloc_gnt=0, count=3. Next cycle alloc_idx=2 and a grant succeeds.
5. count=3, alloc_req + iss_ack in the same cycle -> count stays 3; the new entry is not in iss_oh that cycle even with rdy=all-ones.
6. count=3, assert flush with alloc_req & iss_ack -> next cycle valid=0, count=0, empty=1. Same for rst asserted mid-stream.
